// File: rtl/mem_sync_ctl_if.sv
// Request/acknowledge bus between a master model and mem_sync_ctl.
// Carries the request fields, the completion signals and a debug copy of the FSM state.
interface mem_sync_ctl_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    // Handshake: the master pulses req for one cycle with we/addr/wdata/be valid
    // alongside it. The request is taken only when busy is low. A req seen while
    // busy is high is dropped and reported by a one-cycle ovf pulse. Each accepted
    // request ends with exactly one ack pulse. For a read, rdata is valid during
    // that ack cycle and holds until the next read completes.
    logic            req;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   rdata;
    logic            ack;
    logic            busy;
    logic            ovf;
    logic [1:0]      dbg_state;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ack, busy, ovf, dbg_state
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ack, busy, ovf, dbg_state
    );
endinterface

// File: rtl/mem_sync_ctl.sv
// Single-port byte-masked RAM behind a req/ack handshake.
// Read and write latencies are programmable in whole clock cycles.
module mem_sync_ctl #(
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int WDELAY = 2,
    parameter int RDELAY = 3
) (
    input  logic          clk,
    input  logic          rst,
    mem_sync_ctl_if.slave bus
);
    localparam int NB   = DW / 8;
    localparam int MAXD = (WDELAY > RDELAY) ? WDELAY : RDELAY;
    localparam int CW   = $clog2(MAXD + 1);
    localparam logic [CW-1:0] WLOAD = CW'(WDELAY - 1);
    localparam logic [CW-1:0] RLOAD = CW'(RDELAY - 1);

    generate
        if ((DW % 8) != 0 || WDELAY < 1 || RDELAY < 1) begin : g_bad_params
            $fatal(1, "mem_sync_ctl: DW must be a multiple of 8 and both delays must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   load_cnt;
    logic            cap_we;
    logic [AW-1:0]   cap_addr;
    logic [DW-1:0]   cap_wdata;
    logic [NB-1:0]   cap_be;
    logic [DW-1:0]   rdata_q;
    logic            ack_q;
    logic            busy_q;
    logic            ovf_q;
    logic [DW-1:0]   mem [0:(1<<AW)-1];

    always_comb begin
        load_cnt = bus.we ? WLOAD : RLOAD;
    end

    // Reads sample the array on the edge that enters DONE, so rdata is valid with ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= bus.req && busy_q;
            ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        cap_we    <= bus.we;
                        cap_addr  <= bus.addr;
                        cap_wdata <= bus.wdata;
                        cap_be    <= bus.be;
                        cnt       <= load_cnt;
                        busy_q    <= 1'b1;
                        if (load_cnt == '0) begin
                            state <= DONE;
                            ack_q <= 1'b1;
                            if (!bus.we) begin
                                rdata_q <= mem[bus.addr];
                            end
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        ack_q <= 1'b1;
                        if (!cap_we) begin
                            rdata_q <= mem[cap_addr];
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // The write lands on the edge leaving DONE; a reset on that edge discards it.
    always_ff @(posedge clk) begin
        if (!rst && state == DONE && cap_we) begin
            for (int i = 0; i < NB; i++) begin
                if (cap_be[i]) begin
                    mem[cap_addr][8*i +: 8] <= cap_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.ack       = ack_q;
    assign bus.busy      = busy_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_mem_sync_ctl.sv
// Bench for mem_sync_ctl: two instances (default and AW=4/DW=32/1-cycle latency)
// checked every cycle against an edge-counting reference model plus literal spot checks.
module tb_mem_sync_ctl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_sync_ctl_if #(.AW(8), .DW(16)) ifa ();
    mem_sync_ctl_if #(.AW(4), .DW(32)) ifb ();

    mem_sync_ctl #(.AW(8), .DW(16), .WDELAY(2), .RDELAY(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    mem_sync_ctl #(.AW(4), .DW(32), .WDELAY(1), .RDELAY(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Inputs and outputs of both instances widened into common arrays.
    logic        m_req [2];
    logic        m_we  [2];
    logic [7:0]  m_addr[2];
    logic [31:0] m_wdata[2];
    logic [3:0]  m_be  [2];
    logic [31:0] d_rdata[2];
    logic        d_ack [2];
    logic        d_busy[2];
    logic        d_ovf [2];

    always_comb begin
        m_req[0]   = ifa.req;
        m_we[0]    = ifa.we;
        m_addr[0]  = ifa.addr;
        m_wdata[0] = {16'h0, ifa.wdata};
        m_be[0]    = {2'b00, ifa.be};
        m_req[1]   = ifb.req;
        m_we[1]    = ifb.we;
        m_addr[1]  = {4'h0, ifb.addr};
        m_wdata[1] = ifb.wdata;
        m_be[1]    = ifb.be;
        d_rdata[0] = {16'h0, ifa.rdata};
        d_ack[0]   = ifa.ack;
        d_busy[0]  = ifa.busy;
        d_ovf[0]   = ifa.ovf;
        d_rdata[1] = ifb.rdata;
        d_ack[1]   = ifb.ack;
        d_busy[1]  = ifb.busy;
        d_ovf[1]   = ifb.ovf;
    end

    // Reference model: operation accepted at edge k acks at k+D-1, commits at k+D.
    function automatic int dly(int i, bit w);
        if (i == 0) return w ? 2 : 3;
        return 1;
    endfunction

    int          edge_n = 0;
    bit          model_ok = 1'b0;
    bit          pend  [2] = '{1'b0, 1'b0};
    int          acc   [2];
    bit          p_we  [2];
    logic [7:0]  p_addr[2];
    logic [31:0] p_wdata[2];
    logic [3:0]  p_be  [2];
    logic [31:0] mmem  [2][256];
    logic [31:0] e_rdata[2];
    bit          e_ack [2];
    bit          e_busy[2];
    bit          e_ovf [2];

    initial forever begin
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                pend[i]    = 1'b0;
                e_ack[i]   = 1'b0;
                e_busy[i]  = 1'b0;
                e_ovf[i]   = 1'b0;
                e_rdata[i] = '0;
            end else begin
                e_ovf[i] = m_req[i] && pend[i];
                if (pend[i] && edge_n == acc[i] + dly(i, p_we[i])) begin
                    if (p_we[i]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (p_be[i][b]) mmem[i][p_addr[i]][8*b +: 8] = p_wdata[i][8*b +: 8];
                        end
                    end
                    pend[i] = 1'b0;
                end else if (!pend[i] && m_req[i]) begin
                    pend[i]    = 1'b1;
                    acc[i]     = edge_n;
                    p_we[i]    = m_we[i];
                    p_addr[i]  = m_addr[i];
                    p_wdata[i] = m_wdata[i];
                    p_be[i]    = m_be[i];
                end
                e_busy[i] = pend[i];
                e_ack[i]  = pend[i] && (edge_n == acc[i] + dly(i, p_we[i]) - 1);
                if (e_ack[i] && !p_we[i]) e_rdata[i] = mmem[i][p_addr[i]];
            end
        end
        if (rst) model_ok = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("model_rdata%0d", i), d_rdata[i], e_rdata[i]);
                check($sformatf("model_ack%0d", i), 32'(d_ack[i]), 32'(e_ack[i]));
                check($sformatf("model_busy%0d", i), 32'(d_busy[i]), 32'(e_busy[i]));
                check($sformatf("model_ovf%0d", i), 32'(d_ovf[i]), 32'(e_ovf[i]));
            end
        end
    end

    // Drivers: called at a negedge; req is held for exactly one rising edge.
    task automatic op_a(bit w, logic [7:0] a, logic [15:0] d, logic [1:0] b);
        ifa.req = 1'b1; ifa.we = w; ifa.addr = a; ifa.wdata = d; ifa.be = b;
        @(negedge clk);
        ifa.req = 1'b0;
    endtask

    task automatic op_b(bit w, logic [3:0] a, logic [31:0] d, logic [3:0] b);
        ifb.req = 1'b1; ifb.we = w; ifb.addr = a; ifb.wdata = d; ifb.be = b;
        @(negedge clk);
        ifb.req = 1'b0;
    endtask

    task automatic wait_ack_a(string nm);
        int c = 0;
        while (!ifa.ack && c < 20) begin
            @(negedge clk);
            c++;
        end
        check({nm, "_ack"}, 32'(ifa.ack), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        ifa.req = 1'b0; ifa.we = 1'b0; ifa.addr = '0; ifa.wdata = '0; ifa.be = '0;
        ifb.req = 1'b0; ifb.we = 1'b0; ifb.addr = '0; ifb.wdata = '0; ifb.be = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_rdata", 32'(ifa.rdata), 32'h0);
        check("rst_ack", 32'(ifa.ack), 32'h0);
        check("rst_busy", 32'(ifa.busy), 32'h0);
        check("rst_ovf", 32'(ifa.ovf), 32'h0);
        check("rst_rdata_b", ifb.rdata, 32'h0);

        // Write latency: busy from accept, ack for exactly one cycle.
        op_a(1'b1, 8'h10, 16'hBEEF, 2'b11);
        check("wr_busy0", 32'(ifa.busy), 32'd1);
        check("wr_ack0", 32'(ifa.ack), 32'd0);
        @(negedge clk);
        check("wr_ack1", 32'(ifa.ack), 32'd1);
        check("wr_busy1", 32'(ifa.busy), 32'd1);
        @(negedge clk);
        check("wr_ack2", 32'(ifa.ack), 32'd0);
        check("wr_busy2", 32'(ifa.busy), 32'd0);
        op_a(1'b0, 8'h10, 16'h0, 2'b00);
        @(negedge clk);
        check("rd_noack", 32'(ifa.ack), 32'd0);
        @(negedge clk);
        check("rd_ack", 32'(ifa.ack), 32'd1);
        check("rd_beef", 32'(ifa.rdata), 32'hBEEF);
        @(negedge clk);

        // Partial byte write, then an all-disabled write.
        op_a(1'b1, 8'h10, 16'h1234, 2'b01);
        wait_ack_a("wr_lo");
        @(negedge clk);
        op_a(1'b0, 8'h10, 16'h0, 2'b00);
        wait_ack_a("rd_lo");
        check("rd_be34", 32'(ifa.rdata), 32'hBE34);
        @(negedge clk);
        op_a(1'b1, 8'h10, 16'hFFFF, 2'b00);
        wait_ack_a("wr_be0");
        @(negedge clk);
        op_a(1'b0, 8'h10, 16'h0, 2'b00);
        wait_ack_a("rd_be0");
        check("rd_be0_data", 32'(ifa.rdata), 32'hBE34);
        @(negedge clk);

        // Overflow: req on the second busy cycle of a read is dropped.
        op_a(1'b0, 8'h10, 16'h0, 2'b00);
        @(negedge clk);
        ifa.req = 1'b1; ifa.we = 1'b1; ifa.addr = 8'h10; ifa.wdata = 16'h0000; ifa.be = 2'b11;
        @(negedge clk);
        ifa.req = 1'b0;
        check("ovf_pulse", 32'(ifa.ovf), 32'd1);
        check("ovf_rdata", 32'(ifa.rdata), 32'hBE34);
        n = ifa.ack ? 1 : 0;
        repeat (6) begin
            @(negedge clk);
            if (ifa.ack) n++;
        end
        check("ovf_ack_count", 32'(n), 32'd1);
        op_a(1'b0, 8'h10, 16'h0, 2'b00);
        wait_ack_a("rd_after_ovf");
        check("rd_after_ovf_data", 32'(ifa.rdata), 32'hBE34);
        @(negedge clk);

        // Reset one edge before commit aborts the write; array survives reset.
        op_a(1'b1, 8'h30, 16'h0F0F, 2'b11);
        wait_ack_a("wr_0f0f");
        @(negedge clk);
        op_a(1'b1, 8'h20, 16'hAAAA, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ack", 32'(ifa.ack), 32'd0);
        check("abort_busy", 32'(ifa.busy), 32'd0);
        check("abort_rdata", 32'(ifa.rdata), 32'h0);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (ifa.ack) n++;
        end
        check("abort_no_ack", 32'(n), 32'd0);
        op_a(1'b1, 8'h20, 16'h5555, 2'b11);
        wait_ack_a("wr_5555");
        @(negedge clk);
        op_a(1'b0, 8'h20, 16'h0, 2'b00);
        wait_ack_a("rd_5555");
        check("rd_5555_data", 32'(ifa.rdata), 32'h5555);
        @(negedge clk);
        op_a(1'b0, 8'h30, 16'h0, 2'b00);
        wait_ack_a("rd_0f0f");
        check("rd_0f0f_data", 32'(ifa.rdata), 32'h0F0F);
        @(negedge clk);

        // Single-cycle instance: ack right after accept, one op every 2 cycles.
        op_b(1'b1, 4'hF, 32'h0, 4'b1111);
        check("b_wr0_ack", 32'(ifb.ack), 32'd1);
        @(negedge clk);
        check("b_idle_ack", 32'(ifb.ack), 32'd0);
        check("b_idle_busy", 32'(ifb.busy), 32'd0);
        op_b(1'b1, 4'hF, 32'hDEADBEEF, 4'b1010);
        check("b_wr1_ack", 32'(ifb.ack), 32'd1);
        @(negedge clk);
        op_b(1'b0, 4'hF, 32'h0, 4'b0000);
        check("b_rd_ack", 32'(ifb.ack), 32'd1);
        check("b_rd_data", ifb.rdata, 32'hDE00BE00);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
